// File: rtl/mpsoc_ahb3_master_port.sv
// -----------------------------------------------------------------------------
// mpsoc_ahb3_master_port
//
// AHB3-Lite initiator. Turns a request/response command stream into single
// (HBURST=SINGLE) AHB3-Lite transfers. The address phase (A-stage) and the
// data phase (D-stage) are pipelined, so one transfer can be issued per cycle.
// The initiator honours slave wait states and the two-cycle ERROR response.
//
// Ports
//   HCLK, HRESETn        bus clock, asynchronous active-low reset
//   cmd_req/cmd_ack      command handshake (cmd_ack is combinational)
//   cmd_we, cmd_addr,    command direction, byte address, HSIZE encoding
//   cmd_size, cmd_wdata  and write data
//   rsp_valid, rsp_rdata one-cycle response pulse per accepted command, in order.
//   rsp_err              rsp_rdata is zero for writes and errors.
//   HSEL ... HMASTLOCK   AHB3-Lite address- and data-phase outputs
//   HRDATA, HREADY,      AHB3-Lite slave response inputs
//   HRESP
// -----------------------------------------------------------------------------
module mpsoc_ahb3_master_port #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
) (
    input  logic            HCLK,
    input  logic            HRESETn,

    input  logic            cmd_req,
    output logic            cmd_ack,
    input  logic            cmd_we,
    input  logic [PLEN-1:0] cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [XLEN-1:0] cmd_wdata,

    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,

    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    // A-stage (address phase)
    logic            a_valid_reg, a_valid_next;
    logic            a_we_reg,    a_we_next;
    logic [PLEN-1:0] a_addr_reg,  a_addr_next;
    logic [2:0]      a_size_reg,  a_size_next;
    logic [XLEN-1:0] a_wdata_reg, a_wdata_next;

    // D-stage (data phase)
    logic            d_valid_reg, d_valid_next;
    logic            d_we_reg,    d_we_next;
    logic [XLEN-1:0] d_wdata_reg, d_wdata_next;

    // Set when an A-stage transfer was cancelled by an ERROR response; its
    // error response is still owed to the requester.
    logic            cancel_pend_reg, cancel_pend_next;

    // Response register
    logic            rsp_valid_reg, rsp_valid_next;
    logic            rsp_err_reg,   rsp_err_next;
    logic [XLEN-1:0] rsp_rdata_reg, rsp_rdata_next;

    logic err1;
    logic d_done;

    // First ERROR cycle: slave signals ERROR while still stalling.
    assign err1   = d_valid_reg & HRESP & ~HREADY;
    assign d_done = d_valid_reg & HREADY;

    // No acceptance during reset, while the A-stage is stalled, in the first
    // error cycle, or while a cancelled response is still owed (keeps order).
    assign cmd_ack = HRESETn & cmd_req & (~a_valid_reg | HREADY) & ~err1 & ~cancel_pend_reg;

    always_comb begin
        a_valid_next     = a_valid_reg;
        a_we_next        = a_we_reg;
        a_addr_next      = a_addr_reg;
        a_size_next      = a_size_reg;
        a_wdata_next     = a_wdata_reg;
        d_valid_next     = d_valid_reg;
        d_we_next        = d_we_reg;
        d_wdata_next     = d_wdata_reg;
        cancel_pend_next = cancel_pend_reg;
        rsp_valid_next   = 1'b0;
        rsp_err_next     = 1'b0;
        rsp_rdata_next   = '0;

        // Bus ready: A-stage advances into the D-stage and goes IDLE unless
        // reloaded below. Address outputs keep their last value when IDLE.
        if (HREADY) begin
            d_valid_next = a_valid_reg;
            if (a_valid_reg) begin
                d_we_next    = a_we_reg;
                d_wdata_next = a_wdata_reg;
            end
            a_valid_next = 1'b0;
        end

        // First error cycle: drop the pipelined address phase so it never
        // gets a data phase; remember that its response is owed.
        if (err1) begin
            a_valid_next     = 1'b0;
            cancel_pend_next = cancel_pend_reg | a_valid_reg;
        end

        // An idle A-stage may be loaded even while HREADY is low.
        if (cmd_ack) begin
            a_valid_next = 1'b1;
            a_we_next    = cmd_we;
            a_addr_next  = cmd_addr;
            a_size_next  = cmd_size;
            a_wdata_next = cmd_wdata;
        end

        if (d_done) begin
            rsp_valid_next = 1'b1;
            rsp_err_next   = HRESP;
            if (!HRESP && !d_we_reg) begin
                rsp_rdata_next = HRDATA;
            end
        end else if (cancel_pend_reg && !d_valid_reg) begin
            // The cycle after the erroring transfer's response.
            rsp_valid_next   = 1'b1;
            rsp_err_next     = 1'b1;
            cancel_pend_next = 1'b0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            a_valid_reg     <= 1'b0;
            a_we_reg        <= 1'b0;
            a_addr_reg      <= '0;
            a_size_reg      <= '0;
            a_wdata_reg     <= '0;
            d_valid_reg     <= 1'b0;
            d_we_reg        <= 1'b0;
            d_wdata_reg     <= '0;
            cancel_pend_reg <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_err_reg     <= 1'b0;
            rsp_rdata_reg   <= '0;
        end else begin
            a_valid_reg     <= a_valid_next;
            a_we_reg        <= a_we_next;
            a_addr_reg      <= a_addr_next;
            a_size_reg      <= a_size_next;
            a_wdata_reg     <= a_wdata_next;
            d_valid_reg     <= d_valid_next;
            d_we_reg        <= d_we_next;
            d_wdata_reg     <= d_wdata_next;
            cancel_pend_reg <= cancel_pend_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_err_reg     <= rsp_err_next;
            rsp_rdata_reg   <= rsp_rdata_next;
        end
    end

    assign HSEL      = a_valid_reg;
    assign HTRANS    = a_valid_reg ? TRANS_NONSEQ : TRANS_IDLE;
    assign HADDR     = a_addr_reg;
    assign HWRITE    = a_we_reg;
    assign HSIZE     = a_size_reg;
    assign HWDATA    = d_wdata_reg;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_mpsoc_ahb3_master_port.sv
// -----------------------------------------------------------------------------
// tb_mpsoc_ahb3_master_port
//
// Directed bench for mpsoc_ahb3_master_port. Each table row is one clock
// cycle: the inputs are applied just after the rising edge and the outputs
// are compared on the falling edge. Reset behaviour is covered by
// hand-written sequences.
// -----------------------------------------------------------------------------
module tb_mpsoc_ahb3_master_port;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_req;
    logic        cmd_ack;
    logic        cmd_we;
    logic [63:0] cmd_addr;
    logic [2:0]  cmd_size;
    logic [63:0] cmd_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        rsp_err;
    logic        HSEL;
    logic [63:0] HADDR;
    logic [63:0] HWDATA;
    logic [63:0] HRDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic        HREADY;
    logic        HRESP;

    mpsoc_ahb3_master_port #(.XLEN(64), .PLEN(64)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_req   (cmd_req),
        .cmd_ack   (cmd_ack),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        req;
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic        hready;
        logic        hresp;
        logic [63:0] hrdata;
        logic        ack;
        logic [1:0]  htrans;
        logic [63:0] haddr;
        logic        hwrite;
        logic [63:0] hwdata;
        logic        rv;
        logic        re;
        logic [63:0] rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(
        input logic req, input logic we, input logic [63:0] addr, input logic [63:0] wdata,
        input logic hready, input logic hresp, input logic [63:0] hrdata,
        input logic ack, input logic [1:0] htrans, input logic [63:0] haddr,
        input logic hwrite, input logic [63:0] hwdata,
        input logic rv, input logic re, input logic [63:0] rd);
        vec_t r;
        r.req = req; r.we = we; r.addr = addr; r.wdata = wdata;
        r.hready = hready; r.hresp = hresp; r.hrdata = hrdata;
        r.ack = ack; r.htrans = htrans; r.haddr = haddr; r.hwrite = hwrite;
        r.hwdata = hwdata; r.rv = rv; r.re = re; r.rd = rd;
        return r;
    endfunction

    localparam logic [63:0] D1  = 64'hDEADBEEF_01234567;
    localparam logic [63:0] W0  = 64'hA0A0_0000_0000_0001;
    localparam logic [63:0] W1  = 64'hA0A0_0000_0000_0002;
    localparam logic [63:0] W2  = 64'hA0A0_0000_0000_0003;
    localparam logic [63:0] W3  = 64'hA0A0_0000_0000_0004;
    localparam logic [63:0] W4  = 64'h0BAD_CAFE_0000_0048;
    localparam logic [63:0] W5  = 64'h3030_3030_3030_3030;
    localparam logic [63:0] W6  = 64'h6666_0000_6666_0060;
    localparam logic [63:0] R1  = 64'hCAFE_F00D_1234_5678;
    localparam logic [63:0] R2  = 64'h5555_AAAA_5555_AAAA;
    localparam logic [63:0] R3  = 64'h1357_9BDF_2468_ACE0;
    localparam logic [63:0] BAD = 64'hBAD0_BAD0_BAD0_BAD0;

    task automatic chk_reset_values(input string tag);
        chk({tag, ".HTRANS"},    64'(HTRANS),    64'h0);
        chk({tag, ".HSEL"},      64'(HSEL),      64'h0);
        chk({tag, ".HADDR"},     HADDR,          64'h0);
        chk({tag, ".HWDATA"},    HWDATA,         64'h0);
        chk({tag, ".HWRITE"},    64'(HWRITE),    64'h0);
        chk({tag, ".HSIZE"},     64'(HSIZE),     64'h0);
        chk({tag, ".HBURST"},    64'(HBURST),    64'h0);
        chk({tag, ".HPROT"},     64'(HPROT),     64'h3);
        chk({tag, ".HMASTLOCK"}, 64'(HMASTLOCK), 64'h0);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'h0);
        chk({tag, ".rsp_err"},   64'(rsp_err),   64'h0);
        chk({tag, ".rsp_rdata"}, rsp_rdata,      64'h0);
        chk({tag, ".cmd_ack"},   64'(cmd_ack),   64'h0);
    endtask

    initial begin
        // Single write then read
        vecs.push_back(v(1,1,64'h10,D1, 1,0,0,   1,2'b00,64'h10-64'h10,0,0,  0,0,0));
        vecs.push_back(v(1,0,64'h10,0,  1,0,0,   1,2'b10,64'h10,1,0,         0,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b10,64'h10,0,D1,        0,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,D1,  0,2'b00,64'h10,0,0,         1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h10,0,0,         1,0,D1));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h10,0,0,         0,0,0));
        // Back-to-back writes
        vecs.push_back(v(1,1,64'h00,W0, 1,0,0,   1,2'b00,64'h10,0,0,         0,0,0));
        vecs.push_back(v(1,1,64'h08,W1, 1,0,0,   1,2'b10,64'h00,1,0,         0,0,0));
        vecs.push_back(v(1,1,64'h10,W2, 1,0,0,   1,2'b10,64'h08,1,W0,        0,0,0));
        vecs.push_back(v(1,1,64'h18,W3, 1,0,0,   1,2'b10,64'h10,1,W1,        1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b10,64'h18,1,W2,        1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h18,1,W3,        1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h18,1,W3,        1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h18,1,W3,        0,0,0));
        // Two wait states in a read data phase, write pipelined behind it
        vecs.push_back(v(1,0,64'h40,0,  1,0,0,   1,2'b00,64'h18,1,W3,        0,0,0));
        vecs.push_back(v(1,1,64'h48,W4, 1,0,0,   1,2'b10,64'h40,0,W3,        0,0,0));
        vecs.push_back(v(1,0,64'h50,0,  0,0,0,   0,2'b10,64'h48,1,0,         0,0,0));
        vecs.push_back(v(1,0,64'h50,0,  0,0,0,   0,2'b10,64'h48,1,0,         0,0,0));
        vecs.push_back(v(1,0,64'h50,0,  1,0,R1,  1,2'b10,64'h48,1,0,         0,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b10,64'h50,0,W4,        1,0,R1));
        vecs.push_back(v(0,0,0,0,       1,0,R2,  0,2'b00,64'h50,0,0,         1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h50,0,0,         1,0,R2));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h50,0,0,         0,0,0));
        // ERROR on first read cancels the pipelined second read
        vecs.push_back(v(1,0,64'h20,0,  1,0,0,   1,2'b00,64'h50,0,0,         0,0,0));
        vecs.push_back(v(1,0,64'h28,0,  1,0,0,   1,2'b10,64'h20,0,0,         0,0,0));
        vecs.push_back(v(1,1,64'h30,W5, 0,1,BAD, 0,2'b10,64'h28,0,0,         0,0,0));
        vecs.push_back(v(1,1,64'h30,W5, 1,1,BAD, 0,2'b00,64'h28,0,0,         0,0,0));
        vecs.push_back(v(1,1,64'h30,W5, 1,0,0,   0,2'b00,64'h28,0,0,         1,1,0));
        vecs.push_back(v(1,1,64'h30,W5, 1,0,0,   1,2'b00,64'h28,0,0,         1,1,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b10,64'h30,1,0,         0,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h30,1,W5,        0,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h30,1,W5,        1,0,0));
        vecs.push_back(v(0,0,0,0,       1,0,0,   0,2'b00,64'h30,1,W5,        0,0,0));

        // Reset state, with a request presented
        HRESETn   = 1'b0;
        cmd_req   = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 64'h99;
        cmd_size  = 3'd3;
        cmd_wdata = 64'h1;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        HRDATA    = '0;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk_reset_values("reset");
        $display("reset: htrans=%b rsp_valid=%b cmd_ack=%b", HTRANS, rsp_valid, cmd_ack);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cmd_req = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge HCLK);
            #1;
            cmd_req   = vecs[i].req;
            cmd_we    = vecs[i].we;
            cmd_addr  = vecs[i].addr;
            cmd_wdata = vecs[i].wdata;
            cmd_size  = 3'd3;
            HREADY    = vecs[i].hready;
            HRESP     = vecs[i].hresp;
            HRDATA    = vecs[i].hrdata;
            @(negedge HCLK);
            $display("vec %0d: ack=%b htrans=%b haddr=%h hwdata=%h rsp_valid=%b rsp_err=%b rsp_rdata=%h",
                     i, cmd_ack, HTRANS, HADDR, HWDATA, rsp_valid, rsp_err, rsp_rdata);
            chk($sformatf("v%0d.cmd_ack", i),   64'(cmd_ack),   64'(vecs[i].ack));
            chk($sformatf("v%0d.HTRANS", i),    64'(HTRANS),    64'(vecs[i].htrans));
            chk($sformatf("v%0d.HSEL", i),      64'(HSEL),      64'(vecs[i].htrans == 2'b10));
            chk($sformatf("v%0d.HADDR", i),     HADDR,          vecs[i].haddr);
            chk($sformatf("v%0d.HWRITE", i),    64'(HWRITE),    64'(vecs[i].hwrite));
            chk($sformatf("v%0d.HWDATA", i),    HWDATA,         vecs[i].hwdata);
            chk($sformatf("v%0d.rsp_valid", i), 64'(rsp_valid), 64'(vecs[i].rv));
            chk($sformatf("v%0d.rsp_err", i),   64'(rsp_err),   64'(vecs[i].re));
            chk($sformatf("v%0d.rsp_rdata", i), rsp_rdata,      vecs[i].rd);
        end

        // Reset in the middle of a wait-stated write
        @(posedge HCLK);
        #1;
        cmd_req = 1'b1; cmd_we = 1'b1; cmd_addr = 64'h60; cmd_wdata = W6; HREADY = 1'b1;
        @(negedge HCLK);
        chk("rst_seq.ack", 64'(cmd_ack), 64'h1);
        @(posedge HCLK);
        #1;
        cmd_req = 1'b0;
        @(negedge HCLK);
        chk("rst_seq.htrans_nonseq", 64'(HTRANS), 64'h2);
        chk("rst_seq.haddr", HADDR, 64'h60);
        @(posedge HCLK);
        #1;
        HREADY = 1'b0;
        @(negedge HCLK);
        chk("rst_seq.hwdata_w1", HWDATA, W6);
        @(posedge HCLK);
        #1;
        @(negedge HCLK);
        chk("rst_seq.hwdata_w2", HWDATA, W6);
        chk("rst_seq.no_rsp_wait", 64'(rsp_valid), 64'h0);
        #2;
        HRESETn = 1'b0;
        cmd_req = 1'b1;
        #1;
        chk_reset_values("midreset");
        $display("mid-op reset: htrans=%b hwdata=%h rsp_valid=%b cmd_ack=%b", HTRANS, HWDATA, rsp_valid, cmd_ack);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        cmd_req = 1'b0;
        HREADY  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            chk($sformatf("post_reset%0d.rsp_valid", k), 64'(rsp_valid), 64'h0);
            chk($sformatf("post_reset%0d.HTRANS", k),    64'(HTRANS),    64'h0);
            @(posedge HCLK);
            #1;
        end

        // Next command completes normally: accept at N, response in N+3
        cmd_req = 1'b1; cmd_we = 1'b0; cmd_addr = 64'h68; cmd_wdata = '0; cmd_size = 3'd3;
        @(negedge HCLK);
        chk("after_reset.ack", 64'(cmd_ack), 64'h1);
        @(posedge HCLK);
        #1;
        cmd_req = 1'b0;
        @(negedge HCLK);
        chk("after_reset.HTRANS", 64'(HTRANS), 64'h2);
        chk("after_reset.HADDR", HADDR, 64'h68);
        chk("after_reset.HSIZE", 64'(HSIZE), 64'h3);
        @(posedge HCLK);
        #1;
        HRDATA = R3;
        @(negedge HCLK);
        chk("after_reset.rsp_early", 64'(rsp_valid), 64'h0);
        @(posedge HCLK);
        #1;
        HRDATA = '0;
        @(negedge HCLK);
        $display("after reset read: rsp_valid=%b rsp_err=%b rsp_rdata=%h", rsp_valid, rsp_err, rsp_rdata);
        chk("after_reset.rsp_valid", 64'(rsp_valid), 64'h1);
        chk("after_reset.rsp_err",   64'(rsp_err),   64'h0);
        chk("after_reset.rsp_rdata", rsp_rdata,      R3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
